// File: rtl/pam4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pam4_pkg
// Description : Shared constants and FSM state encoding for the PAM4 framer.
// Revision    : 1.0
// ============================================================================
package pam4_pkg;

    localparam int                 c_SYM_W            = 2;
    localparam logic [7:0]         c_SFD_DEFAULT      = 8'hD5;
    localparam logic [c_SYM_W-1:0] c_IDLE_SYM_DEFAULT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pam4_sym_tick.sv
`default_nettype none
// ============================================================================
// Module      : pam4_sym_tick
// Description : Symbol-period divider; o_tick is high in the last clock of each period.
// Revision    : 1.0
// ============================================================================
module pam4_sym_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int                c_CW   = $clog2(CLK_DIV);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(CLK_DIV - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/pam4_symbol_framer.sv
`default_nettype none
// ============================================================================
// Module      : pam4_symbol_framer
// Description : Frames payload bytes (preamble, SFD, payload, gap) into PAM4 symbols.
// Revision    : 1.0
// ============================================================================
module pam4_symbol_framer
    import pam4_pkg::*;
#(
    parameter int                 CLK_DIV      = 4,
    parameter int                 PREAMBLE_LEN = 8,
    parameter logic [7:0]         SFD          = c_SFD_DEFAULT,
    parameter int                 FRAME_LEN    = 16,
    parameter int                 GAP_LEN      = 4,
    parameter logic [c_SYM_W-1:0] IDLE_SYM     = c_IDLE_SYM_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [c_SYM_W-1:0] sym_out,
    output logic               sym_stb,
    output logic               frame_act,
    output logic               underrun
);

    localparam int c_SYM_CNT_MAX = (PREAMBLE_LEN > GAP_LEN) ? PREAMBLE_LEN : GAP_LEN;
    localparam int c_SYM_CW      = $clog2(c_SYM_CNT_MAX);
    localparam int c_BYTE_CW     = $clog2(FRAME_LEN + 1);

    localparam logic [c_SYM_CW-1:0]  c_PRE_LAST  = c_SYM_CW'(PREAMBLE_LEN - 1);
    localparam logic [c_SYM_CW-1:0]  c_GAP_LAST  = c_SYM_CW'(GAP_LEN - 1);
    localparam logic [c_BYTE_CW-1:0] c_BYTE_LAST = c_BYTE_CW'(FRAME_LEN);
    localparam logic [c_SYM_W-1:0]   c_PRE_LO    = 2'b00;
    localparam logic [c_SYM_W-1:0]   c_PRE_HI    = 2'b11;

    logic w_tick;

    pam4_sym_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_sym_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    state_t               r_state,     w_state_nxt;
    logic [c_SYM_CW-1:0]  r_sym_cnt,   w_sym_cnt_nxt;
    logic [1:0]           r_pair,      w_pair_nxt;
    logic [7:0]           r_shift,     w_shift_nxt;
    logic [c_BYTE_CW-1:0] r_byte_cnt,  w_byte_cnt_nxt;
    logic [c_SYM_W-1:0]   r_sym,       w_sym_nxt;
    logic                 r_frame_act, w_frame_act_nxt;
    logic                 r_underrun,  w_underrun_nxt;
    logic                 r_sym_stb;
    logic [7:0]           r_buf;
    logic                 r_buf_full;
    logic                 r_ready;
    logic                 w_load;
    logic                 w_accept;
    logic                 w_buf_full_nxt;

    assign w_accept       = s_valid && r_ready;
    assign w_buf_full_nxt = w_accept || (r_buf_full && !w_load);

    always_comb begin
        w_state_nxt     = r_state;
        w_sym_cnt_nxt   = r_sym_cnt;
        w_pair_nxt      = r_pair;
        w_shift_nxt     = r_shift;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_sym_nxt       = r_sym;
        w_frame_act_nxt = r_frame_act;
        w_underrun_nxt  = 1'b0;
        w_load          = 1'b0;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    w_sym_nxt = IDLE_SYM;
                    if (r_buf_full) begin
                        w_state_nxt     = ST_PREAMBLE;
                        w_sym_cnt_nxt   = '0;
                        w_byte_cnt_nxt  = '0;
                        w_sym_nxt       = c_PRE_LO;
                        w_frame_act_nxt = 1'b1;
                    end
                end
                ST_PREAMBLE: begin
                    if (r_sym_cnt == c_PRE_LAST) begin
                        w_state_nxt = ST_SFD;
                        w_sym_nxt   = SFD[7:6];
                        w_shift_nxt = {SFD[5:0], 2'b00};
                        w_pair_nxt  = 2'd0;
                    end else begin
                        w_sym_cnt_nxt = r_sym_cnt + 1'b1;
                        w_sym_nxt     = r_sym_cnt[0] ? c_PRE_LO : c_PRE_HI;
                    end
                end
                ST_SFD, ST_PAYLOAD: begin
                    // SFD and payload share the shifter; a byte boundary follows pair 3
                    if (r_pair != 2'd3) begin
                        w_sym_nxt   = r_shift[7:6];
                        w_shift_nxt = r_shift << 2;
                        w_pair_nxt  = r_pair + 1'b1;
                    end else if (r_state == ST_PAYLOAD && r_byte_cnt == c_BYTE_LAST) begin
                        w_state_nxt     = ST_GAP;
                        w_sym_cnt_nxt   = '0;
                        w_sym_nxt       = IDLE_SYM;
                        w_frame_act_nxt = 1'b0;
                    end else if (r_buf_full) begin
                        w_load         = 1'b1;
                        w_state_nxt    = ST_PAYLOAD;
                        w_sym_nxt      = r_buf[7:6];
                        w_shift_nxt    = {r_buf[5:0], 2'b00};
                        w_pair_nxt     = 2'd0;
                        w_byte_cnt_nxt = (r_state == ST_SFD) ? c_BYTE_CW'(1) : r_byte_cnt + 1'b1;
                    end else begin
                        w_state_nxt     = ST_GAP;
                        w_sym_cnt_nxt   = '0;
                        w_sym_nxt       = IDLE_SYM;
                        w_frame_act_nxt = 1'b0;
                        w_underrun_nxt  = 1'b1;
                    end
                end
                ST_GAP: begin
                    w_sym_nxt = IDLE_SYM;
                    if (r_sym_cnt == c_GAP_LAST) begin
                        // A waiting byte starts its preamble right after the last gap symbol
                        if (r_buf_full) begin
                            w_state_nxt     = ST_PREAMBLE;
                            w_sym_cnt_nxt   = '0;
                            w_byte_cnt_nxt  = '0;
                            w_sym_nxt       = c_PRE_LO;
                            w_frame_act_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_sym_cnt_nxt = r_sym_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_sym_nxt   = IDLE_SYM;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_sym_cnt   <= '0;
            r_pair      <= 2'd0;
            r_shift     <= 8'd0;
            r_byte_cnt  <= '0;
            r_sym       <= IDLE_SYM;
            r_frame_act <= 1'b0;
            r_underrun  <= 1'b0;
            r_sym_stb   <= 1'b0;
            r_buf       <= 8'd0;
            r_buf_full  <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sym_cnt   <= w_sym_cnt_nxt;
            r_pair      <= w_pair_nxt;
            r_shift     <= w_shift_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_sym       <= w_sym_nxt;
            r_frame_act <= w_frame_act_nxt;
            r_underrun  <= w_underrun_nxt;
            r_sym_stb   <= w_tick;
            if (w_accept) begin
                r_buf <= s_data;
            end
            r_buf_full  <= w_buf_full_nxt;
            r_ready     <= !w_buf_full_nxt;
        end
    end

    assign s_ready   = r_ready;
    assign sym_out   = r_sym;
    assign sym_stb   = r_sym_stb;
    assign frame_act = r_frame_act;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire
